boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 9, giving the word address width of the target memory (capacity 2^ADDR_W words).
REQ-002 The module SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port rx_data, input, 8 bits: received byte, qualified by rx_valid.
REQ-006 The module SHALL have port rx_valid, input, 1 bit: one-cycle strobe, one byte per high cycle.
REQ-007 The module SHALL have port mem_wen, output, 1 bit: word write strobe to the program memory.
REQ-008 The module SHALL have port mem_addr, output, ADDR_W bits: word address for the write.
REQ-009 The module SHALL have port mem_wdata, output, 32 bits: word to write.
REQ-010 The module SHALL have port cpu_resetn, output, 1 bit: active-low reset held on the CPU until load completes.
REQ-011 The module SHALL have port done, output, 1 bit: image loaded, CPU released.
REQ-012 The module SHALL have port error, output, 1 bit: frame rejected.

Function
REQ-013 Frame format SHALL be: SYNC_BYTE, count low byte, count high byte (16-bit word count N), then 4*N data bytes, each word little-endian; mem_wdata SHALL be {b3,b2,b1,b0}.
REQ-014 States SHALL be IDLE, LEN0, LEN1, DATA, CHK (BOOT_CHECKSUM_EN only), DONE, ERR; state advances only on cycles with rx_valid high.
REQ-015 IDLE SHALL discard every byte except SYNC_BYTE, which moves to LEN0; LEN0 -> LEN1 -> DATA on the next two bytes.
REQ-016 On the count's high byte, N equal to 0 or greater than 2^ADDR_W SHALL move to ERR instead of DATA.
REQ-017 mem_wen SHALL pulse high for exactly one cycle, one cycle after the cycle carrying a word's 4th byte, with mem_addr and mem_wdata valid in that same cycle.
REQ-018 Word addresses SHALL start at 0 and increment by 1 per write; the last write SHALL be at N-1; no address wrap occurs.
REQ-019 When the N-th word's 4th byte is accepted, the next state SHALL be CHK (with BOOT_CHECKSUM_EN) or DONE (without).
REQ-020 DONE SHALL assert done=1 and cpu_resetn=1 and ignore all further bytes until reset.
REQ-021 ERR SHALL assert error=1 with cpu_resetn=0; a SYNC_BYTE received in ERR SHALL clear error and enter LEN0; other bytes are ignored.
REQ-022 cpu_resetn SHALL be 0 in every state except DONE.
REQ-023 mem_wen SHALL never assert outside the cycle after a completed word in DATA.

Reset
REQ-024 reset SHALL, synchronously and at any point including mid-frame, force IDLE, mem_wen=0, mem_addr=0, mem_wdata=0, cpu_resetn=0, done=0, error=0, and clear byte, word and checksum counters.
REQ-025 A pending write pulse SHALL be cancelled if reset is high in the cycle it would occur.

Configuration
REQ-026 With macro BOOT_CHECKSUM_EN defined, the module SHALL maintain the 8-bit modulo-256 sum of all data bytes and expect one trailing checksum byte in CHK; match -> DONE, mismatch -> ERR.
REQ-027 Without BOOT_CHECKSUM_EN, there SHALL be no CHK state and no checksum byte, and the module SHALL enter DONE directly after the last word.

Verification
REQ-028 Bytes A5 02 00 11 22 33 44 55 66 77 88 (plus checksum 64 if enabled) -> writes 0x44332211 at addr 0 and 0x88776655 at addr 1, each 1 cycle after its 4th byte; then done=1, cpu_resetn=1.
REQ-029 Bytes 00 FF then A5 01 00 DE AD BE EF with rx_valid gaps of 0-5 cycles -> leading bytes ignored; single write 0xEFBEADDE at addr 0.
REQ-030 A5 00 00 -> error=1, no mem_wen, cpu_resetn=0; following valid frame -> error clears, load completes.
REQ-031 With ADDR_W=9, count 0x0201 (513) -> ERR; count 0x0200 -> 512 writes, last at addr 511.
REQ-032 reset asserted after 6 data bytes of a 2-word frame -> all outputs at reset values next cycle; a fresh complete frame then loads from addr 0.
REQ-033 BOOT_CHECKSUM_EN: the REQ-028 frame with checksum byte 00 -> error=1, cpu_resetn stays 0, both words already written.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses a sync/count/data frame and writes 32-bit words to program memory.
// Optional trailing checksum byte is enabled with macro BOOT_CHECKSUM_EN.
module boot_loader #(
    parameter int          ADDR_W    = 9,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_resetn,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
`endif
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_nwords;
    logic [1:0]        r_byte_idx;
    logic [15:0]       r_word_cnt;
    logic [23:0]       r_shift;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic [15:0] w_len;
    logic        w_len_bad;
    logic        w_last_word;

    assign w_len       = {rx_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > MAX_WORDS);
    assign w_last_word = ((r_word_cnt + 16'd1) == r_nwords);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len_lo   <= '0;
            r_nwords   <= '0;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_wen <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_state    <= S_LEN0;
                            r_byte_idx <= '0;
                            r_word_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
                            r_sum      <= '0;
`endif
                        end
                    end
                    S_LEN0: begin
                        r_len_lo <= rx_data;
                        r_state  <= S_LEN1;
                    end
                    S_LEN1: begin
                        if (w_len_bad) begin
                            r_state <= S_ERR;
                        end else begin
                            r_nwords <= w_len;
                            r_state  <= S_DATA;
                        end
                    end
                    S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                        r_sum <= r_sum + rx_data;
`endif
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Bytes arrive little-endian; shifting in at the top leaves {b2,b1,b0}.
                        if (r_byte_idx == 2'd3) begin
                            r_wen      <= 1'b1;
                            r_wdata    <= {rx_data, r_shift};
                            r_addr     <= r_word_cnt[ADDR_W-1:0];
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (w_last_word) begin
`ifdef BOOT_CHECKSUM_EN
                                r_state <= S_CHK;
`else
                                r_state <= S_DONE;
`endif
                            end
                        end else begin
                            r_shift <= {rx_data, r_shift[23:8]};
                        end
                    end
`ifdef BOOT_CHECKSUM_EN
                    S_CHK: begin
                        r_state <= (rx_data == r_sum) ? S_DONE : S_ERR;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // A write due in a cycle where reset is already high must not reach memory.
    assign mem_wen    = r_wen & ~reset;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign done       = (r_state == S_DONE);
    assign cpu_resetn = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus randomized frames against a
// frame-position reference model.
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int AW = 9;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_resetn;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 hunting, 1 in frame, 2 loaded, 3 rejected.
    int         m_mode = 0;
    int         m_pos  = 0;
    int         m_n    = 0;
    int         m_nlo  = 0;
    int         m_sum  = 0;
    logic [7:0] m_w [4];

    boot_loader #(.ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_resetn(cpu_resetn), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("done", {31'd0, done}, {31'd0, m_mode == 2});
        chk("cpu_resetn", {31'd0, cpu_resetn}, {31'd0, m_mode == 2});
        chk("error", {31'd0, error}, {31'd0, m_mode == 3});
    endtask

    // One clock cycle; a valid byte is applied to the model, outputs checked after the edge.
    task automatic step(input bit v, input logic [7:0] b);
        bit          exp_wen;
        int          exp_addr;
        logic [31:0] exp_data;
        int          k;
        exp_wen  = 1'b0;
        exp_addr = 0;
        exp_data = '0;
        @(negedge clk);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
        @(posedge clk);
        #1;
        if (v) begin
            if (m_mode == 0 || m_mode == 3) begin
                if (b == SYNC) begin
                    m_mode = 1; m_pos = 1; m_sum = 0;
                end
            end else if (m_mode == 1) begin
                if (m_pos == 1) begin
                    m_nlo = b; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_n = b * 256 + m_nlo;
                    if (m_n == 0 || m_n > (1 << AW)) m_mode = 3;
                    else m_pos = 3;
                end else begin
                    k = m_pos - 3;
                    if (k < 4 * m_n) begin
                        m_sum = (m_sum + b) % 256;
                        m_w[k % 4] = b;
                        if (k % 4 == 3) begin
                            exp_wen  = 1'b1;
                            exp_addr = k / 4;
                            exp_data = {m_w[3], m_w[2], m_w[1], m_w[0]};
                        end
                        if (k == 4 * m_n - 1 && !CK_EN) m_mode = 2;
                        m_pos++;
                    end else begin
                        m_mode = (b == m_sum) ? 2 : 3;
                    end
                end
            end
        end
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
        if (exp_wen) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", mem_wdata, exp_data);
        end
        chk_status();
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) step(1'b0, 8'h00);
        step(1'b1, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        m_mode = 0; m_pos = 0;
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk_status();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full frame of n random words; checksum corrupted when ck_ok is clear.
    task automatic send_frame(input int n, input bit ck_ok, input int gap);
        int s;
        logic [7:0] b;
        s = 0;
        send(SYNC, gap);
        send(8'(n), gap);
        send(8'(n >> 8), gap);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s += b;
            send(b, gap);
        end
        if (CK_EN) send(ck_ok ? 8'(s) : 8'(s + 1), gap);
    endtask

    initial begin
        logic [7:0] f28 [11];
        logic [7:0] f29 [9];
        logic [7:0] b;
        f28 = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        f29 = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        do_reset();

        // Two-word reference frame, then trailing bytes ignored once loaded.
        foreach (f28[i]) send(f28[i], 0);
        if (CK_EN) send(8'h64, 0);
        chk("f28_done", {31'd0, done}, 32'd1);
        send(SYNC, 0);
        send(8'h12, 2);
        do_reset();

        // Leading junk and idle gaps.
        foreach (f29[i]) send(f29[i], 5);
        do_reset();

        // Zero-length frame rejected, then recovery by a good frame.
        send(SYNC, 0); send(8'h00, 0); send(8'h00, 0);
        chk("zero_err", {31'd0, error}, 32'd1);
        send(8'h33, 1);
        send_frame(2, 1'b1, 2);
        do_reset();

        // Capacity limits: 513 rejected, 512 accepted.
        send(SYNC, 0); send(8'h01, 0); send(8'h02, 0);
        send_frame(512, 1'b1, 0);
        do_reset();

        // Reset mid-frame, then a fresh load from address 0.
        send(SYNC, 0); send(8'h02, 0); send(8'h00, 0);
        repeat (6) send(8'($urandom), 0);
        do_reset();
        send_frame(2, 1'b1, 1);
        do_reset();

        // Reset raised just after the edge that would present a write.
        send(SYNC, 0); send(8'h01, 0); send(8'h00, 0);
        repeat (3) send(8'h5A, 0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("cancel_wen", {31'd0, mem_wen}, 32'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        m_mode = 0; m_pos = 0;
        chk_status();
        @(negedge clk);
        reset = 1'b0;

`ifdef BOOT_CHECKSUM_EN
        foreach (f28[i]) send(f28[i], 0);
        send(8'h00, 0);
        chk("ck_bad_err", {31'd0, error}, 32'd1);
        do_reset();
`endif

        // Randomized frames with junk, gaps, bad counts and post-load noise.
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(3, 0)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                send(b, 2);
            end
            if ($urandom_range(5, 0) == 0) begin
                send(SYNC, 1); send(8'h00, 1); send(8'h00, 1);
            end
            send_frame(int'($urandom_range(5, 1)), $urandom_range(4, 0) != 0, int'($urandom_range(3, 0)));
            repeat ($urandom_range(3, 0)) send(($urandom_range(1, 0) != 0) ? SYNC : 8'($urandom), 1);
            if ($urandom_range(2, 0) == 0) begin
                send(SYNC, 0);
                send_frame(1, 1'b1, 0);
            end
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
